laser_tx_serializer: RTL and testbench

LASER_TX_SERIALIZER -- requirements
Module: laser_tx_serializer

---
 rtl/laser_tx_serializer.sv | 179 +++++++++++++++++
 tb/tb_laser_tx_serializer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_tx_serializer.sv
// -----------------------------------------------------------------------------
// laser_tx_serializer
//
// Purpose:
//   Pulls bytes from an upstream byte queue and sends each one on an optical
//   emitter as an asynchronous-style frame:
//     start (light off), 8 data bits LSB first (1 = light on),
//     even parity bit, stop (light on).
//   Each bit lasts CLKS_PER_BIT clocks. After PKT_LEN bytes, the emitter is
//   held on for GAP_BITS bit periods. tx_done then pulses once and the byte
//   count starts again from zero.
//
// Parameters:
//   CLKS_PER_BIT - clocks per laser bit period (>= 2)
//   PKT_LEN      - bytes per packet (1..1023)
//   GAP_BITS     - idle bit periods inserted after each packet (>= 1)
//
// Ports:
//   clock      in   single clock, rising edge
//   reset      in   synchronous, active-high reset
//   en         in   permits a new byte to be accepted
//   data_valid in   upstream byte available
//   data_in    in   upstream byte, valid whenever data_valid = 1
//   data_read  out  one-cycle pulse that consumes data_in
//   laser_tx   out  emitter drive, 2'b11 = on, 2'b00 = off (registered)
//   busy       out  high whenever the FSM is not idle
//   tx_done    out  one-cycle pulse when a packet (including its gap) ends
//   byte_ct    out  bytes fully sent in the current packet
// -----------------------------------------------------------------------------
module laser_tx_serializer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PKT_LEN      = 512,
    parameter int GAP_BITS     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       data_valid,
    input  logic [7:0] data_in,
    output logic       data_read,
    output logic [1:0] laser_tx,
    output logic       busy,
    output logic       tx_done,
    output logic [9:0] byte_ct
);

    localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
    localparam int TIMER_W  = $clog2(CLKS_PER_BIT);
    localparam int GAP_W    = $clog2(GAP_CLKS);

    localparam logic [TIMER_W-1:0] BIT_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(GAP_CLKS - 1);
    localparam logic [9:0]         PKT_FULL = 10'(PKT_LEN);

    localparam logic [1:0] LIGHT_ON  = 2'b11;
    localparam logic [1:0] LIGHT_OFF = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } state_t;

    state_t             state;
    logic [7:0]         data_reg;
    logic [TIMER_W-1:0] bit_timer;
    logic [2:0]         bit_idx;
    logic [GAP_W-1:0]   gap_timer;

    logic               accept;
    logic               bit_done;
    logic [2:0]         next_idx;
    logic [9:0]         byte_ct_next;

    // The read strobe must coincide with the cycle the byte is latched, so it
    // is decoded from the current state and inputs; reset masks it so a byte
    // is never consumed by a cycle that will be thrown away.
    assign accept       = (state == ST_IDLE) && en && data_valid && !reset;
    assign data_read    = accept;
    assign busy         = (state != ST_IDLE);
    assign bit_done     = (bit_timer == BIT_LAST);
    assign next_idx     = bit_idx + 3'd1;
    assign byte_ct_next = byte_ct + 10'd1;

    // laser_tx is loaded on the same edge that enters each bit, so the
    // emitter level always matches the state held during that bit period.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            laser_tx  <= LIGHT_ON;
            tx_done   <= 1'b0;
            byte_ct   <= 10'd0;
            bit_timer <= '0;
            bit_idx   <= 3'd0;
            gap_timer <= '0;
            data_reg  <= 8'd0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    laser_tx <= LIGHT_ON;
                    if (accept) begin
                        data_reg  <= data_in;
                        bit_timer <= '0;
                        laser_tx  <= LIGHT_OFF;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        bit_timer <= '0;
                        bit_idx   <= 3'd0;
                        laser_tx  <= {2{data_reg[0]}};
                        state     <= ST_DATA;
                    end else begin
                        bit_timer <= bit_timer + TIMER_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        bit_timer <= '0;
                        if (bit_idx == 3'd7) begin
                            laser_tx <= {2{^data_reg}};
                            state    <= ST_PARITY;
                        end else begin
                            bit_idx  <= next_idx;
                            laser_tx <= {2{data_reg[next_idx]}};
                        end
                    end else begin
                        bit_timer <= bit_timer + TIMER_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        bit_timer <= '0;
                        laser_tx  <= LIGHT_ON;
                        state     <= ST_STOP;
                    end else begin
                        bit_timer <= bit_timer + TIMER_W'(1);
                    end
                end
                ST_STOP: begin
                    laser_tx <= LIGHT_ON;
                    if (bit_done) begin
                        bit_timer <= '0;
                        byte_ct   <= byte_ct_next;
                        if (byte_ct_next == PKT_FULL) begin
                            gap_timer <= '0;
                            state     <= ST_GAP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        bit_timer <= bit_timer + TIMER_W'(1);
                    end
                end
                ST_GAP: begin
                    laser_tx <= LIGHT_ON;
                    if (gap_timer == GAP_LAST) begin
                        gap_timer <= '0;
                        byte_ct   <= 10'd0;
                        tx_done   <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        gap_timer <= gap_timer + GAP_W'(1);
                    end
                end
                default: begin
                    laser_tx <= LIGHT_ON;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_laser_tx_serializer
//
// Purpose:
//   Self-checking bench for laser_tx_serializer (CLKS_PER_BIT=4, PKT_LEN=2,
//   GAP_BITS=2). A waveform model predicts, cycle by cycle, the emitter level,
//   busy, byte_ct, tx_done and data_read from the line-encoding rules; a
//   compare process checks the DUT against it on every falling edge. A few
//   directed scenarios add literal expectations on top.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_laser_tx_serializer;

    localparam int CPB      = 4;
    localparam int PKT      = 2;
    localparam int GAPB     = 2;
    localparam int GAP_CLKS = GAPB * CPB;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic       data_valid;
    logic [7:0] data_in;
    logic       data_read;
    logic [1:0] laser_tx;
    logic       busy;
    logic       tx_done;
    logic [9:0] byte_ct;

    int n_checks = 0;
    int n_fail   = 0;

    laser_tx_serializer #(
        .CLKS_PER_BIT(CPB),
        .PKT_LEN     (PKT),
        .GAP_BITS    (GAPB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .data_valid(data_valid),
        .data_in   (data_in),
        .data_read (data_read),
        .laser_tx  (laser_tx),
        .busy      (busy),
        .tx_done   (tx_done),
        .byte_ct   (byte_ct)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // Model: one record per clock cycle of activity. An empty queue means the
    // line is idle (light on, not busy).
    typedef struct packed {
        logic [1:0] laser;
        logic       busy;
        logic [9:0] ct;
        logic       end_frame;
        logic       end_gap;
    } rec_t;

    rec_t q[$];
    int   model_count  = 0;
    bit   done_pending = 0;
    bit   model_on     = 0;

    rec_t cur;
    bit   from_q;
    logic exp_rd;
    logic exp_done;

    task automatic push_frame(input logic [7:0] b);
        rec_t r;
        logic lvl;
        for (int k = 0; k < 11; k++) begin
            if (k == 0)       lvl = 1'b0;
            else if (k <= 8)  lvl = b[k-1];
            else if (k == 9)  lvl = ^b;
            else              lvl = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                r.laser     = {2{lvl}};
                r.busy      = 1'b1;
                r.ct        = 10'(model_count);
                r.end_frame = (k == 10) && (c == CPB - 1);
                r.end_gap   = 1'b0;
                q.push_back(r);
            end
        end
        if (model_count + 1 == PKT) begin
            for (int c = 0; c < GAP_CLKS; c++) begin
                r.laser     = 2'b11;
                r.busy      = 1'b1;
                r.ct        = 10'(PKT);
                r.end_frame = 1'b0;
                r.end_gap   = (c == GAP_CLKS - 1);
                q.push_back(r);
            end
        end
    endtask

    // Compare on the falling edge, then advance the model using the inputs
    // that the coming rising edge will sample.
    always @(negedge clock) begin
        if (model_on) begin
            from_q = (q.size() > 0);
            if (from_q) cur = q[0];
            else        cur = '{laser: 2'b11, busy: 1'b0, ct: 10'(model_count),
                                end_frame: 1'b0, end_gap: 1'b0};
            exp_rd   = !from_q && en && data_valid && !reset;
            exp_done = !from_q && done_pending;

            checkOutput("laser_tx",  32'(laser_tx),  32'(cur.laser));
            checkOutput("busy",      32'(busy),      32'(cur.busy));
            checkOutput("byte_ct",   32'(byte_ct),   32'(cur.ct));
            checkOutput("tx_done",   32'(tx_done),   32'(exp_done));
            checkOutput("data_read", 32'(data_read), 32'(exp_rd));

            if (reset) begin
                q.delete();
                model_count  = 0;
                done_pending = 0;
            end else if (from_q) begin
                cur = q.pop_front();
                if (cur.end_frame) model_count++;
                if (cur.end_gap) begin
                    model_count  = 0;
                    done_pending = 1;
                end
            end else begin
                done_pending = 0;
                if (en && data_valid) push_frame(data_in);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic e, input logic v,
                                 input logic [7:0] d);
        reset      = r;
        en         = e;
        data_valid = v;
        data_in    = d;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Offers a byte and waits (bounded) for it to be consumed. Returns at
    // posedge+1 of the first START cycle, with data_valid still asserted.
    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        en         = 1'b1;
        data_valid = 1'b1;
        data_in    = b;
        for (int i = 0; i < 200; i++) begin
            #2;
            if (data_read) got = 1;
            @(posedge clock);
            #1;
            if (got) break;
        end
        checkOutput("accept_timeout", 32'(got), 32'd1);
    endtask

    logic [1:0] samples[44];
    int         a5_bits[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    int         done_seen;

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        @(posedge clock);
        #1;
        model_on = 1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        $display("[TB] reset released");

        checkOutput("reset_laser", 32'(laser_tx), 32'h3);
        checkOutput("reset_busy",  32'(busy),     32'h0);
        checkOutput("reset_ct",    32'(byte_ct),  32'h0);

        // Starvation: nothing available, line must stay idle.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A);
        repeat (20) @(posedge clock);
        #1;
        checkOutput("starve_laser", 32'(laser_tx), 32'h3);

        // Single byte 0xA5, with data_valid dropped right after acceptance.
        send_byte(8'hA5);
        data_valid = 1'b0;
        for (int c = 0; c < 44; c++) begin
            samples[c] = laser_tx;
            @(posedge clock);
            #1;
        end
        for (int b = 0; b < 11; b++)
            checkOutput("a5_bit", 32'(samples[4*b+2]), (a5_bits[b] != 0) ? 32'h3 : 32'h0);
        checkOutput("a5_byte_ct", 32'(byte_ct), 32'd1);
        checkOutput("a5_idle",    32'(busy),    32'd0);

        // Full packet: 0x00 then 0xFF, continuously valid.
        do_reset(2);
        send_byte(8'h00);
        data_in = 8'hFF;
        send_byte(8'hFF);
        data_valid = 1'b0;
        done_seen  = 0;
        for (int c = 0; c < 100; c++) begin
            if (tx_done) done_seen++;
            @(posedge clock);
            #1;
        end
        checkOutput("pkt_done_count", 32'(done_seen), 32'd1);
        checkOutput("pkt_byte_ct",    32'(byte_ct),   32'd0);

        // Odd-weight byte: parity bit must be on.
        do_reset(2);
        send_byte(8'h01);
        data_valid = 1'b0;
        repeat (37) @(posedge clock);
        #1;
        checkOutput("parity_01", 32'(laser_tx), 32'h3);
        repeat (20) @(posedge clock);
        #1;

        // en dropped mid-frame with data still valid.
        do_reset(2);
        send_byte(8'h96);
        repeat (10) @(posedge clock);
        #1;
        en = 1'b0;
        repeat (60) @(posedge clock);
        #1;
        checkOutput("en_hold_busy", 32'(busy), 32'd0);
        en = 1'b1;
        #2;
        checkOutput("en_resume_read", 32'(data_read), 32'd1);
        @(posedge clock);
        #1;
        data_valid = 1'b0;
        repeat (50) @(posedge clock);
        #1;

        // Reset at clock 20 of a frame.
        do_reset(2);
        send_byte(8'hC3);
        data_valid = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("abort_laser", 32'(laser_tx), 32'h3);
        checkOutput("abort_busy",  32'(busy),     32'd0);
        checkOutput("abort_ct",    32'(byte_ct),  32'd0);
        send_byte(8'h3C);
        data_valid = 1'b0;
        repeat (50) @(posedge clock);
        #1;

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom % 300) == 0, ($urandom % 4) != 0,
                          ($urandom % 3) != 0, 8'($urandom));
            @(posedge clock);
            #1;
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (100) @(posedge clock);
        #1;

        model_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
